maze_ctrl: RTL and testbench

- Sequencing FSM for the DFS maze-walk datapath. It drives the location registers, adder, direction select and path stack.
- Cell lookups go to an external 16x16 maze memory, addressed by the datapath's next-location bus.
- Explores neighbours in fixed order, marks visited cells, and backtracks via stack pop.
- Ends in one of two ways: reaches the goal and replays the stored path, or reports failure when the stack empties.

---
 rtl/maze_ctrl_pkg.sv | 25 ++
 rtl/maze_ctrl_wait.sv | 32 +++
 rtl/maze_ctrl.sv | 159 +++++++++++++++
 tb/tb_maze_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_ctrl_pkg.sv
// Shared definitions for the DFS maze-walk controller.
//   state_t : FSM state encoding (4 bits)
//   DIR_*   : neighbour direction codes driven on dir
package maze_ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StMark    = 4'd1,
    StCheck   = 4'd2,
    StRead    = 4'd3,
    StEval    = 4'd4,
    StMove    = 4'd5,
    StNextDir = 4'd6,
    StBack    = 4'd7,
    StGoal    = 4'd8,
    StReplay  = 4'd9,
    StFail    = 4'd10
  } state_t;

  localparam logic [1:0] DIR_YM = 2'b00;  // y-1
  localparam logic [1:0] DIR_XP = 2'b01;  // x+1
  localparam logic [1:0] DIR_XM = 2'b10;  // x-1
  localparam logic [1:0] DIR_YP = 2'b11;  // y+1

endpackage

// File: rtl/maze_ctrl_wait.sv
// Maze-memory latency counter.
//   clk, rst : clock, async active-high reset
//   load     : preload MEM_LAT-1
//   dec      : count down by one (saturates at zero)
//   zero     : counter is zero (read data valid on the next cycle)
module maze_ctrl_wait #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam logic [1:0] LoadVal = 2'(MEM_LAT - 1);

  logic [1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 2'd0;
    end else if (load) begin
      cnt_q <= LoadVal;
    end else if (dec && (cnt_q != 2'd0)) begin
      cnt_q <= cnt_q - 2'd1;
    end
  end

  assign zero = (cnt_q == 2'd0);

endmodule

// File: rtl/maze_ctrl.sv
// Sequencing FSM for the DFS maze-walk datapath.
//   start              : begins a solve from idle
//   cntReach, empStck,
//   curLoc             : datapath status (edge of grid, stack empty, location)
//   memRdData          : maze cell at the next location (1 = wall/visited)
//   rgLd, adderEn, dir,
//   push, pop, done,
//   run                : datapath controls
//   memRd, memWr,
//   memWrData          : maze memory access at the next location
//   busy, found, fail  : solve status (found/fail sticky until next start)
module maze_ctrl
  import maze_ctrl_pkg::*;
#(
  parameter logic [7:0]  GOAL_LOC = 8'hFF,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cntReach,
  input  logic       empStck,
  input  logic [7:0] curLoc,
  input  logic       memRdData,
  output logic       rgLd,
  output logic       adderEn,
  output logic [1:0] dir,
  output logic       push,
  output logic       pop,
  output logic       done,
  output logic       run,
  output logic       memRd,
  output logic       memWr,
  output logic       memWrData,
  output logic       busy,
  output logic       found,
  output logic       fail
);

  state_t     state_q;
  logic [1:0] dir_q;
  logic       busy_q, found_q, fail_q;
  logic       wait_load, wait_zero;

  // Arm the latency counter on the CHECK -> READ transition.
  assign wait_load = (state_q == StCheck) && (curLoc != GOAL_LOC) && !cntReach;

  maze_ctrl_wait #(
    .MEM_LAT(MEM_LAT)
  ) u_wait (
    .clk (clk),
    .rst (rst),
    .load(wait_load),
    .dec (state_q == StRead),
    .zero(wait_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      dir_q   <= DIR_YM;
      busy_q  <= 1'b0;
      found_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            found_q <= 1'b0;
            fail_q  <= 1'b0;
            busy_q  <= 1'b1;
            dir_q   <= DIR_YM;
            state_q <= StMark;
          end
        end
        StMark:  state_q <= StCheck;
        StCheck: begin
          if (curLoc == GOAL_LOC) state_q <= StGoal;
          else if (cntReach)      state_q <= StNextDir;
          else                    state_q <= StRead;
        end
        StRead: begin
          if (wait_zero) state_q <= StEval;
        end
        StEval:  state_q <= memRdData ? StNextDir : StMove;
        StMove: begin
          dir_q   <= DIR_YM;
          state_q <= StCheck;
        end
        StNextDir: begin
          if (dir_q != DIR_YP) begin
            dir_q   <= dir_q + 2'd1;
            state_q <= StCheck;
          end else if (empStck) begin
            // Flags change on entry so fail is visible during the FAIL cycle.
            fail_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StFail;
          end else begin
            state_q <= StBack;
          end
        end
        StBack: begin
          dir_q   <= DIR_YM;
          state_q <= StCheck;
        end
        StGoal:  state_q <= StReplay;
        StReplay: begin
          if (empStck) begin
            found_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StFail:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    rgLd    = 1'b0;
    adderEn = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    done    = 1'b0;
    run     = 1'b0;
    memRd   = 1'b0;
    memWr   = 1'b0;
    unique case (state_q)
      StMark: memWr = 1'b1;
      StRead: begin
        adderEn = 1'b1;
        memRd   = 1'b1;
      end
      StEval: adderEn = 1'b1;
      StMove: begin
        adderEn = 1'b1;
        push    = 1'b1;
        rgLd    = 1'b1;
        memWr   = 1'b1;
      end
      StBack: begin
        pop  = 1'b1;
        rgLd = 1'b1;
      end
      StGoal:   done = 1'b1;
      StReplay: run  = !empStck;
      default:  ;
    endcase
  end

  assign dir       = dir_q;
  assign busy      = busy_q;
  assign found     = found_q;
  assign fail      = fail_q;
  assign memWrData = 1'b1;

endmodule

// File: tb/tb_maze_ctrl.sv
module tb_maze_ctrl;
  import maze_ctrl_pkg::*;

  localparam int KPush = 0, KPop = 1, KDone = 2, KEnd = 3;

  typedef struct {
    int kind;
    int val;   // push: curLoc, pop: popped loc, end: {found, fail}
    int runs;
    int wrs;
  } ev_t;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic       rgLd, adderEn, push, pop, done, run, memRd, memWr, memWrData;
  logic       busy, found, fail;
  logic [1:0] dir;

  // Behavioural datapath, stack and maze memory
  logic [7:0]   cur_loc, next_loc, nb;
  logic [7:0]   stk [256];
  int           sp;
  logic [255:0] mem, wall_cfg;
  logic         dp_clr = 1'b0;
  logic [2:0]   pipe;
  logic         cnt_reach, emp_stck;
  logic [3:0]   cx, cy;

  int  checks = 0, failures = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  maze_ctrl #(
    .GOAL_LOC(8'h02),
    .MEM_LAT (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cntReach (cnt_reach),
    .empStck  (emp_stck),
    .curLoc   (cur_loc),
    .memRdData(pipe[2]),
    .rgLd     (rgLd),
    .adderEn  (adderEn),
    .dir      (dir),
    .push     (push),
    .pop      (pop),
    .done     (done),
    .run      (run),
    .memRd    (memRd),
    .memWr    (memWr),
    .memWrData(memWrData),
    .busy     (busy),
    .found    (found),
    .fail     (fail)
  );

  always_comb begin
    cx = cur_loc[7:4];
    cy = cur_loc[3:0];
    case (dir)
      2'b00:   nb = {cx, cy - 4'd1};
      2'b01:   nb = {cx + 4'd1, cy};
      2'b10:   nb = {cx - 4'd1, cy};
      default: nb = {cx, cy + 4'd1};
    endcase
    cnt_reach = (dir == 2'b00 && cy == 4'd0) || (dir == 2'b01 && cx == 4'd15) ||
                (dir == 2'b10 && cx == 4'd0) || (dir == 2'b11 && cy == 4'd15);
    emp_stck  = (sp == 0);
    if (pop)          next_loc = stk[8'(sp - 1)];
    else if (adderEn) next_loc = nb;
    else              next_loc = cur_loc;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_loc <= 8'h00;
      sp      <= 0;
      pipe    <= 3'b000;
    end else if (dp_clr) begin
      cur_loc <= 8'h00;
      sp      <= 0;
      pipe    <= 3'b000;
      mem     <= wall_cfg;
    end else begin
      if (memWr) mem[next_loc] <= 1'b1;
      if (rgLd) cur_loc <= next_loc;
      if (push) begin
        stk[8'(sp)] <= cur_loc;
        sp          <= sp + 1;
      end else if (pop || run) begin
        sp <= sp - 1;
      end
      pipe <= {pipe[1:0], mem[next_loc]};
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic take(input string name, input int kind, input int act, output ev_t e);
    checks++;
    e = '{kind: -1, val: 0, runs: 0, wrs: 0};
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: got unexpected event kind %0d val 0x%0h, required none", name, kind, act);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != act) begin
        failures++;
        $display("FAIL %s: got kind %0d val 0x%0h required kind %0d val 0x%0h",
                 name, kind, act, e.kind, e.val);
      end
    end
  endtask

  // Monitor: compares DUT events against the scoreboard queue
  int   rd_run = 0, run_cnt = 0, wr_cnt = 0;
  logic busy_prev = 1'b0, dir_after = 1'b0;

  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      rd_run    = 0;
      busy_prev = 1'b0;
      dir_after = 1'b0;
    end else begin
      if (start && !busy) begin
        run_cnt = 0;
        wr_cnt  = 0;
      end
      chk("exclusive", int'({push & pop, memWr & memRd, rgLd & ~(push | pop),
                             memRd & ~adderEn}), 0);
      if (dir_after) begin
        chk("dir_reset", int'(dir), 0);
        dir_after = 1'b0;
      end
      if (memRd) rd_run++;
      else if (rd_run != 0) begin
        chk("read_len", rd_run, 3);
        rd_run = 0;
      end
      if (memWr) wr_cnt++;
      if (run) run_cnt++;
      if (push) begin
        take("push", KPush, int'(cur_loc), e);
        dir_after = 1'b1;
      end
      if (pop) begin
        take("pop", KPop, int'(next_loc), e);
        chk("pop_rgld", int'(rgLd), 1);
        dir_after = 1'b1;
      end
      if (done) take("done", KDone, 0, e);
      if (busy_prev && !busy) begin
        take("end", KEnd, int'({found, fail}), e);
        chk("run_cycles", run_cnt, e.runs);
        chk("mem_writes", wr_cnt, e.wrs);
      end
      busy_prev = busy;
    end
  end

  task automatic exp_ev(input int kind, input int val, input int runs, input int wrs);
    exp_q.push_back('{kind: kind, val: val, runs: runs, wrs: wrs});
  endtask

  task automatic load_maze(input logic [255:0] w);
    wall_cfg = w;
    dp_clr   = 1'b1;
    @(posedge clk);
    #1 dp_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 5000) begin
      @(posedge clk);
      #1 n++;
    end
    chk(name, int'(busy), 0);
    @(negedge clk);
    #1 chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Open maze, goal 02: east along y=0, up at x=15, west along y=1, up to 02.
  task automatic exp_open();
    for (int x = 0; x < 15; x++) exp_ev(KPush, x * 16, 0, 0);
    exp_ev(KPush, 8'hF0, 0, 0);
    for (int x = 15; x >= 1; x--) exp_ev(KPush, x * 16 + 1, 0, 0);
    exp_ev(KPush, 8'h01, 0, 0);
    exp_ev(KDone, 0, 0, 0);
    exp_ev(KEnd, 2'b10, 32, 33);
  endtask

  initial begin
    logic [255:0] w;
    int n;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_held_outputs", int'({rgLd, adderEn, dir, push, pop, done, run, memRd, memWr,
                                  busy, found, fail}), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_state", int'(dut.state_q), int'(StIdle));
    chk("reset_outputs", int'({rgLd, adderEn, dir, push, pop, done, run, memRd, memWr,
                               busy, found, fail}), 0);
    chk("wrdata", int'(memWrData), 1);

    // Open maze
    load_maze('0);
    exp_open();
    pulse_start();
    chk("busy_after_start", int'(busy), 1);
    wait_idle("open_maze");
    chk("open_found", int'({found, fail}), 2'b10);

    // Start cell walled in
    w = '0;
    w[8'h10] = 1'b1;
    w[8'h01] = 1'b1;
    load_maze(w);
    exp_ev(KEnd, 2'b01, 0, 1);
    pulse_start();
    chk("found_cleared", int'(found), 0);
    wait_idle("walled_in");

    // Dead-end corridor 00 -> 10 -> 20
    w = '0;
    w[8'h01] = 1'b1;
    w[8'h11] = 1'b1;
    w[8'h21] = 1'b1;
    w[8'h30] = 1'b1;
    load_maze(w);
    exp_ev(KPush, 8'h00, 0, 0);
    exp_ev(KPush, 8'h10, 0, 0);
    exp_ev(KPop, 8'h10, 0, 0);
    exp_ev(KPop, 8'h00, 0, 0);
    exp_ev(KEnd, 2'b01, 0, 3);
    pulse_start();
    wait_idle("dead_end");

    // Reset during READ
    load_maze('0);
    pulse_start();
    n = 0;
    while (!memRd && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk("reached_read", int'(memRd), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", int'({rgLd, adderEn, dir, push, pop, done, run, memRd, memWr,
                                   busy, found, fail}), 0);
    chk("async_rst_state", int'(dut.state_q), int'(StIdle));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Resolve after reset, with a stray start while busy
    load_maze('0);
    exp_open();
    pulse_start();
    repeat (50) @(posedge clk);
    #1;
    pulse_start();
    wait_idle("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
